// File: rtl/dwtthr_if.sv
// Sample/threshold bundle for dwtthr: the producer drives detail samples and hold,
// the threshold block drives the four thresholds and their status.
interface dwtthr_if;
  logic signed [15:0] d1_in;
  logic               d1_valid;
  logic               hold;
  logic signed [15:0] t4d1;
  logic signed [15:0] t4d2;
  logic signed [15:0] t4d3;
  logic signed [15:0] t4a3;
  logic               thr_valid;
  logic               busy;

  modport master (
    output d1_in, d1_valid, hold,
    input  t4d1, t4d2, t4d3, t4a3, thr_valid, busy
  );

  modport slave (
    input  d1_in, d1_valid, hold,
    output t4d1, t4d2, t4d3, t4a3, thr_valid, busy
  );
endinterface

// File: rtl/dwtthr.sv
// Wavelet threshold estimator: mean |d1| per frame of 2**LOG2N samples, scaled
// by four Q4.4 factors through one shared multiplier, published together.
module dwtthr #(
  parameter int unsigned LOG2N = 6,
  parameter int unsigned K1    = 48,
  parameter int unsigned K2    = 34,
  parameter int unsigned K3    = 24,
  parameter int unsigned KA    = 0
) (
  input logic      clk,
  input logic      reset,
  dwtthr_if.slave  bus
);
  localparam int unsigned SW = 15 + LOG2N;

  typedef enum logic [1:0] {ACC, SCALE, UPD} state_t;

  state_t            state, state_next;
  logic [1:0]        idx;
  logic [SW-1:0]     sum, sum_next;
  logic [LOG2N-1:0]  count;
  logic [14:0]       mean;
  logic [14:0]       mag;
  logic [15:0]       neg;
  logic              frame_end;
  logic [7:0]        k_sel;
  logic [22:0]       prod;
  logic [18:0]       scaled;
  logic [14:0]       sat;
  logic              upd_load;
  logic [14:0]       shadow [4];

  always_comb begin
    neg = 16'(-bus.d1_in);
    if (bus.d1_in == 16'sh8000) mag = 15'h7fff;
    else if (bus.d1_in[15])     mag = neg[14:0];
    else                        mag = bus.d1_in[14:0];
  end

  assign sum_next  = sum + SW'(mag);
  assign frame_end = bus.d1_valid && (&count);

  assign prod   = {8'b0, mean} * {15'b0, k_sel};
  assign scaled = prod[22:4];
  assign sat    = (scaled > 19'd32767) ? 15'h7fff : scaled[14:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ACC:     if (frame_end) state_next = SCALE;
      SCALE:   if (idx == 2'd3) state_next = UPD;
      UPD:     state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  always_comb begin
    bus.busy = (state != ACC);
    upd_load = (state == UPD) && !bus.hold;
    unique case (idx)
      2'd0:    k_sel = 8'(K1);
      2'd1:    k_sel = 8'(K2);
      2'd2:    k_sel = 8'(K3);
      default: k_sel = 8'(KA);
    endcase
  end

  // Accumulation runs in every state so a new frame can start during SCALE/UPD.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum   <= '0;
      count <= '0;
      mean  <= '0;
    end else if (bus.d1_valid) begin
      if (frame_end) begin
        mean  <= sum_next[LOG2N +: 15];
        sum   <= '0;
        count <= '0;
      end else begin
        sum   <= sum_next;
        count <= count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      for (int unsigned i = 0; i < 4; i++) shadow[i] <= '0;
    end else if (state == SCALE) begin
      shadow[idx] <= sat;
      idx         <= idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.t4d1      <= '0;
      bus.t4d2      <= '0;
      bus.t4d3      <= '0;
      bus.t4a3      <= '0;
      bus.thr_valid <= 1'b0;
    end else begin
      bus.thr_valid <= upd_load;
      if (upd_load) begin
        bus.t4d1 <= {1'b0, shadow[0]};
        bus.t4d2 <= {1'b0, shadow[1]};
        bus.t4d3 <= {1'b0, shadow[2]};
        bus.t4a3 <= {1'b0, shadow[3]};
      end
    end
  end
endmodule

// File: tb/tb_dwtthr.sv
// Directed bench for dwtthr (LOG2N=3): frame results are queued by a reference
// model at the frame-end edge and checked when the update is due.
module tb_dwtthr;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dwtthr_if bus();

  dwtthr #(.LOG2N(3), .K1(48), .K2(34), .K3(24), .KA(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int due;
    bit discard;
    int e[4];
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   mon_en = 1'b0;
  int   mdl[4] = '{0, 0, 0, 0};
  int   fcnt = 0;
  int   fsum = 0;
  int   ks[4] = '{48, 34, 24, 0};

  always @(posedge clk) cyc++;

  task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int absm(int v);
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int scale(int mean, int k);
    int r;
    r = (mean * k) / 16;
    return (r > 32767) ? 32767 : r;
  endfunction

  bit exp_tv, exp_busy;
  always @(negedge clk) begin
    if (mon_en) begin
      exp_tv   = 1'b0;
      exp_busy = 1'b0;
      if (q.size() > 0) begin
        if (cyc >= q[0].due - 5 && cyc < q[0].due) exp_busy = 1'b1;
        if (cyc == q[0].due) begin
          if (!q[0].discard) begin
            exp_tv = 1'b1;
            mdl = q[0].e;
          end
          void'(q.pop_front());
        end
      end
      check("thr_valid", 32'(bus.thr_valid), 32'(exp_tv));
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("t4d1", 32'(bus.t4d1), mdl[0]);
      check("t4d2", 32'(bus.t4d2), mdl[1]);
      check("t4d3", 32'(bus.t4d3), mdl[2]);
      check("t4a3", 32'(bus.t4a3), mdl[3]);
    end
  end

  task automatic step(logic signed [15:0] v, bit vld);
    exp_t x;
    int mean;
    bus.d1_in    = v;
    bus.d1_valid = vld;
    @(posedge clk);
    #1;
    if (vld) begin
      fsum += absm(int'(v));
      fcnt++;
      if (fcnt == 8) begin
        mean = fsum / 8;
        x.due = cyc + 5;
        x.discard = bus.hold;
        for (int i = 0; i < 4; i++) x.e[i] = scale(mean, ks[i]);
        q.push_back(x);
        fcnt = 0;
        fsum = 0;
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(16'sh1234, 1'b0);
  endtask

  task automatic frame(logic signed [15:0] v);
    for (int i = 0; i < 8; i++) step(v, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.d1_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    mdl = '{0, 0, 0, 0};
    fcnt = 0;
    fsum = 0;
  endtask

  initial begin
    reset = 1'b1;
    bus.d1_in = '0;
    bus.d1_valid = 1'b0;
    bus.hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Back-to-back frame of 100
    frame(16'sd100);
    idle(8);
    check("d1_100_t4d1", 32'(bus.t4d1), 300);
    check("d1_100_t4d2", 32'(bus.t4d2), 212);
    check("d1_100_t4d3", 32'(bus.t4d3), 150);

    // -100 with valid toggling; invalid cycles carry junk data
    for (int i = 0; i < 8; i++) begin
      step(-16'sd100, 1'b1);
      step(16'sh7abc, 1'b0);
    end
    idle(8);
    check("neg100_t4d1", 32'(bus.t4d1), 300);

    // Most negative input saturates
    frame(-16'sd32768);
    idle(8);
    check("sat_t4d1", 32'(bus.t4d1), 32767);
    check("sat_t4d3", 32'(bus.t4d3), 32767);
    check("sat_t4a3", 32'(bus.t4a3), 0);

    // Partial frame discarded by reset
    for (int i = 0; i < 5; i++) step(16'sd1000, 1'b1);
    do_reset();
    frame(16'sd16);
    idle(8);
    check("rst_t4d1", 32'(bus.t4d1), 48);
    check("rst_t4d2", 32'(bus.t4d2), 34);

    // Hold discards frame B, frame C then updates
    frame(16'sd100);
    idle(8);
    bus.hold = 1'b1;
    frame(16'sd200);
    idle(8);
    check("hold_t4d1", 32'(bus.t4d1), 300);
    bus.hold = 1'b0;
    frame(16'sd200);
    idle(8);
    check("frameC_t4d1", 32'(bus.t4d1), 600);
    check("frameC_t4d2", 32'(bus.t4d2), 425);
    check("frameC_t4d3", 32'(bus.t4d3), 300);

    // Next frame starts in the cycle after frame end (during SCALE)
    frame(16'sd100);
    frame(16'sd40);
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    idle(2);
    check("overlap_t4d1", 32'(bus.t4d1), 120);
    check("drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dwtthr.md
DWTTHR -- requirements
Module: dwtthr

Interface
REQ-001 SHALL have parameter LOG2N, default 6, meaning the frame length N = 2**LOG2N valid d1 samples; legal range 3..10.
REQ-002 SHALL have parameter K1, default 48, meaning the unsigned Q4.4 scale for t4d1 (8 bits).
REQ-003 SHALL have parameter K2, default 34, meaning the unsigned Q4.4 scale for t4d2.
REQ-004 SHALL have parameter K3, default 24, meaning the unsigned Q4.4 scale for t4d3.
REQ-005 SHALL have parameter KA, default 0, meaning the unsigned Q4.4 scale for t4a3.
REQ-006 SHALL have port clk, input, 1 bit: the system clock; one clock domain only, all registers on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-008 SHALL have port d1_in, input, 16 bits signed: the level-1 detail sample before thresholding.
REQ-009 SHALL have port d1_valid, input, 1 bit: d1_in is accepted in each cycle where this is high.
REQ-010 SHALL have port hold, input, 1 bit: freezes the threshold outputs.
REQ-011 SHALL have ports t4d1, t4d2, t4d3, t4a3, output, 16 bits signed each: registered thresholds for the denoiser; always >= 0.
REQ-012 SHALL have port thr_valid, output, 1 bit: one-cycle pulse when the thresholds update.
REQ-013 SHALL have port busy, output, 1 bit: high while a scaling sequence is in progress.

Function
REQ-014 SHALL form |d1_in| per accepted sample; -32768 SHALL map to 32767 (saturate).
REQ-015 SHALL sum |d1_in| into an unsigned accumulator of 15+LOG2N bits, which cannot overflow.
REQ-016 SHALL count accepted samples modulo N; cycles where d1_valid is low SHALL change neither the count nor the sum.
REQ-017 On acceptance of sample N-1 (the frame end) the block SHALL do all of the following at that same edge:
  - latch mean = (sum including this sample) >> LOG2N;
  - clear the sum and count to 0;
  - enter SCALE.
REQ-018 Samples accepted during SCALE SHALL accumulate into the new frame; no sample is lost or double-counted.
REQ-019 The state machine SHALL have three states:
  - ACC: accumulate;
  - SCALE: 4 cycles; idx 0..3 selects K1, K2, K3, KA;
  - UPD: 1 cycle;
  - transitions: ACC->SCALE at frame end, SCALE->UPD after idx 3, UPD->ACC.
REQ-020 SCALE SHALL share one 15x8 unsigned multiplier, one product per cycle: shadow[idx] = min((mean*K) >> 4, 32767), truncating.
REQ-021 busy SHALL be high in SCALE and UPD, and low in ACC.
REQ-022 In UPD with hold=0, all four outputs SHALL load simultaneously from shadow and thr_valid SHALL be 1 for exactly that cycle.
REQ-023 Latency: outputs and thr_valid SHALL change at the 5th clock edge after the edge accepting the frame-end sample.
REQ-024 In UPD with hold=1, the outputs SHALL keep their values, thr_valid SHALL stay 0, and that frame's result SHALL be discarded.
REQ-025 Since N >= 8 exceeds the 5-cycle sequence, a frame end SHALL never occur in SCALE or UPD; no overlap handling is required.
REQ-026 The thresholds SHALL be unsigned-valued and fit 0..32767, and SHALL be compared by the denoiser as signed 16-bit values.

Reset
REQ-027 While reset=1 at an edge, the block SHALL clear all of the following:
  - sum, count and mean: 0;
  - state: ACC, idx 0;
  - shadow registers: 0;
  - t4d1, t4d2, t4d3, t4a3: 0;
  - thr_valid and busy: 0.
REQ-028 A reset during SCALE or UPD SHALL abort without updating the outputs; the partial frame SHALL be discarded.
REQ-029 Accumulation SHALL restart from count 0 on the first valid sample after reset is released.

Verification (LOG2N=3, default K values)
REQ-030 Eight valid samples of d1_in=100, back-to-back -> 5 edges after the 8th: t4d1=300, t4d2=212, t4d3=150, t4a3=0, thr_valid pulses once.
REQ-031 Eight samples of -100 with d1_valid toggling every other cycle -> same values as REQ-030, with update timed from the 8th valid sample.
REQ-032 Eight samples of -32768 -> mean 32767; t4d1=t4d2=t4d3=32767 (saturated); t4a3=0.
REQ-033 Five samples of 1000, then reset for 1 cycle, then 8 samples of 16 -> outputs 0 until the update, then t4d1=48, t4d2=34, t4d3=24.
REQ-034 Frame A of 100s, then frame B of 200s with hold=1 during B's UPD -> outputs stay at the REQ-030 values with no thr_valid for B; frame C of 200s with hold=0 -> t4d1=600, t4d2=425, t4d3=300.
REQ-035 A frame-B sample accepted in the cycle after frame A's end, during SCALE -> it is included in frame B's mean.
